// File: rtl/rotl_stepper_if.sv
// rotl_stepper_if: bundles the button/switch inputs and LED/status outputs
// of the rotate-left LED stepper.
//   br    raw push button (asynchronous, may bounce)
//   sw    rotate amount, SHW bits
//   ledr  current LED pattern, WIDTH bits
//   busy  rotation sequence in progress
//   done  one-cycle pulse when a press has been fully applied
// master: the side driving the button and switches (board / bench)
// slave : the stepper itself
interface rotl_stepper_if #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
);
  logic             br;
  logic [SHW-1:0]   sw;
  logic [WIDTH-1:0] ledr;
  logic             busy;
  logic             done;

  modport master (output br, sw, input ledr, busy, done);
  modport slave  (input br, sw, output ledr, busy, done);
endinterface

// File: rtl/rotl_stepper.sv
// rotl_stepper: left-rotating LED pattern register for the board demo.
// The raw button is synchronised through two flops and debounced; every
// clean 0->1 button level change rotates the pattern left by sw positions,
// one position per clock. A press with sw==0 reloads LOAD_VAL instead.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  rotl_stepper_if.slave (br, sw in; ledr, busy, done out)
module rotl_stepper #(
  parameter int               WIDTH     = 8,
  parameter int               SHW       = 3,
  parameter int               DB_CYCLES = 16,
  parameter logic [WIDTH-1:0] LOAD_VAL  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input logic           clk,
  input logic           rst,
  rotl_stepper_if.slave bus
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], v[WIDTH-1]};
  endfunction

  logic             br_p0;
  logic             br_p1;
  logic             lvl;
  logic [CNT_W-1:0] cnt;
  logic             press_p2;

  state_t           state;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] ledr_q;
  logic             busy_q;
  logic             done_q;

  // Stage p0/p1: two-flop synchroniser for the asynchronous button.
  // Stage p2: debounce. cnt counts consecutive cycles where the synchronised
  // button disagrees with the accepted level; any agreement restarts it.
  // press_p2 pulses for one cycle on an accepted 0->1 change only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_p0    <= 1'b0;
      br_p1    <= 1'b0;
      lvl      <= 1'b0;
      cnt      <= '0;
      press_p2 <= 1'b0;
    end else begin
      br_p0    <= bus.br;
      br_p1    <= br_p0;
      press_p2 <= 1'b0;
      if (br_p1 == lvl) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        lvl      <= br_p1;
        cnt      <= '0;
        press_p2 <= br_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Stage p3: rotate sequencer. amt is captured once per press, so switch
  // changes and further presses while shifting have no effect. done is set
  // on the same edge busy drops, so the two never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      amt    <= '0;
      ledr_q <= LOAD_VAL;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (press_p2) begin
            if (bus.sw == '0) begin
              ledr_q <= LOAD_VAL;
              done_q <= 1'b1;
            end else begin
              amt    <= bus.sw;
              busy_q <= 1'b1;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          ledr_q <= rotl1(ledr_q);
          amt    <= amt - SHW'(1);
          if (amt == SHW'(1)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ledr = ledr_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_rotl_stepper.sv
// tb_rotl_stepper: directed bench for rotl_stepper.
// dut_a: LOAD_VAL=8'h01, DB_CYCLES=4 (main checks, debounce, reset cases).
// dut_b: LOAD_VAL=8'h81, DB_CYCLES=1 (wrap-around pattern and a second
// press landing while a rotation is still running).
module tb_rotl_stepper;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  rotl_stepper_if #(.WIDTH(8), .SHW(3)) a_if ();
  rotl_stepper_if #(.WIDTH(8), .SHW(3)) b_if ();

  rotl_stepper #(.WIDTH(8), .SHW(3), .DB_CYCLES(4), .LOAD_VAL(8'h01)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  rotl_stepper #(.WIDTH(8), .SHW(3), .DB_CYCLES(1), .LOAD_VAL(8'h81)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running status counters, sampled on the falling edge.
  int         a_done_n, a_busy_n, a_ovl_n;
  int         b_done_n, b_busy_n, b_ovl_n;
  logic [7:0] a_done_led, b_done_led;

  initial begin
    a_done_n = 0; a_busy_n = 0; a_ovl_n = 0; a_done_led = '0;
    b_done_n = 0; b_busy_n = 0; b_ovl_n = 0; b_done_led = '0;
  end

  always @(negedge clk) begin
    if (a_if.done === 1'b1) begin
      a_done_n   = a_done_n + 1;
      a_done_led = a_if.ledr;
    end
    if (a_if.busy === 1'b1) a_busy_n = a_busy_n + 1;
    if (a_if.busy === 1'b1 && a_if.done === 1'b1) a_ovl_n = a_ovl_n + 1;
    if (b_if.done === 1'b1) begin
      b_done_n   = b_done_n + 1;
      b_done_led = b_if.ledr;
    end
    if (b_if.busy === 1'b1) b_busy_n = b_busy_n + 1;
    if (b_if.busy === 1'b1 && b_if.done === 1'b1) b_ovl_n = b_ovl_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_a(input logic [2:0] s, input int hold);
    @(posedge clk); #1;
    a_if.sw = s;
    a_if.br = 1'b1;
    repeat (hold) @(posedge clk);
    #1 a_if.br = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_b(input logic [2:0] s, input int hold);
    @(posedge clk); #1;
    b_if.sw = s;
    b_if.br = 1'b1;
    repeat (hold) @(posedge clk);
    #1 b_if.br = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
  endtask

  int   d0, bz0, d1, bz1;
  logic seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    a_if.br = 1'b0; a_if.sw = '0;
    b_if.br = 1'b0; b_if.sw = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Reset state
    chk("rst_ledr",   a_if.ledr, 8'h01);
    chk("rst_busy",   a_if.busy, 1'b0);
    chk("rst_done",   a_if.done, 1'b0);
    chk("rst_ledr_b", b_if.ledr, 8'h81);

    // sw=3 held 10 clocks: 01 -> 08, busy 3 cycles, one done at final value
    d0 = a_done_n; bz0 = a_busy_n;
    press_a(3'd3, 10);
    chk("t2_ledr",     a_if.ledr, 8'h08);
    chk("t2_busy_cyc", a_busy_n - bz0, 3);
    chk("t2_done_cnt", a_done_n - d0, 1);
    chk("t2_done_led", a_done_led, 8'h08);

    // Asynchronous reset between clock edges
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_ledr", a_if.ledr, 8'h01);
    chk("arst_busy", a_if.busy, 1'b0);
    chk("arst_done", a_if.done, 1'b0);
    @(negedge clk) rst = 1'b0;

    // Glitch of 3 clocks then 20 clocks of bouncing: nothing accepted
    d0 = a_done_n; bz0 = a_busy_n;
    @(posedge clk); #1 a_if.sw = 3'd2; a_if.br = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_if.br = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 a_if.br = ~a_if.br;
    end
    #1 a_if.br = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t4_ledr", a_if.ledr, 8'h01);
    chk("t4_busy", a_busy_n - bz0, 0);
    chk("t4_done", a_done_n - d0, 0);

    // Clean press still works after the bounce
    press_a(3'd1, 8);
    chk("t4_after_ledr", a_if.ledr, 8'h02);

    // dut_b: sw=0 press loads 81, then sw=7 rotates to C0
    d1 = b_done_n;
    press_b(3'd0, 4);
    chk("t3_load_ledr", b_if.ledr, 8'h81);
    chk("t3_load_done", b_done_n - d1, 1);
    d1 = b_done_n; bz1 = b_busy_n;
    press_b(3'd7, 4);
    chk("t3_ledr",     b_if.ledr, 8'hC0);
    chk("t3_done_cnt", b_done_n - d1, 1);
    chk("t3_busy_cyc", b_busy_n - bz1, 7);
    chk("t3_done_led", b_done_led, 8'hC0);

    // dut_b: sw=5 press, second press and sw=1 while shifting are ignored
    d1 = b_done_n; bz1 = b_busy_n;
    @(posedge clk); #1 b_if.sw = 3'd5; b_if.br = 1'b1;
    @(posedge clk); #1 b_if.br = 1'b0;
    @(posedge clk); #1 b_if.br = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 b_if.sw = 3'd1;
    repeat (2) @(posedge clk);
    #1 b_if.br = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t5_ledr",     b_if.ledr, 8'h18);
    chk("t5_busy_cyc", b_busy_n - bz1, 5);
    chk("t5_done_cnt", b_done_n - d1, 1);
    press_b(3'd0, 4);
    chk("t5_reload", b_if.ledr, 8'h81);

    // dut_a: sw=0 press reloads 01
    d0 = a_done_n;
    press_a(3'd0, 8);
    chk("t5a_reload",   a_if.ledr, 8'h01);
    chk("t5a_done_cnt", a_done_n - d0, 1);

    // sw=7 press, reset after 2 rotates: immediate abort, no done
    d0 = a_done_n;
    @(posedge clk); #1 a_if.sw = 3'd7; a_if.br = 1'b1;
    repeat (5) @(posedge clk);
    #1 a_if.br = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (a_if.busy === 1'b1) seen = 1'b1;
    end
    chk("t6_busy_seen", seen, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("t6_mid_ledr", a_if.ledr, 8'h04);
    rst = 1'b1;
    #1;
    chk("t6_rst_ledr", a_if.ledr, 8'h01);
    chk("t6_rst_busy", a_if.busy, 1'b0);
    @(negedge clk) rst = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);
    chk("t6_no_done", a_done_n - d0, 0);
    chk("t6_idle_ledr", a_if.ledr, 8'h01);
    d0 = a_done_n;
    press_a(3'd2, 8);
    chk("t6_next_ledr", a_if.ledr, 8'h04);
    chk("t6_next_done", a_done_n - d0, 1);

    chk("ovl_a", a_ovl_n, 0);
    chk("ovl_b", b_ovl_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
